// File: rtl/alsu_drv_pkg.sv
// Shared types for the ALSU command driver: opcodes, the ALSU pin bundle,
// FSM states and the park vector used to hold the ALSU result between commands.
package alsu_drv_pkg;

   localparam int ALSU_W = 6;

   localparam logic [2:0] OP_OR    = 3'd0;
   localparam logic [2:0] OP_XOR   = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_MUL   = 3'd3;
   localparam logic [2:0] OP_SHIFT = 3'd4;
   localparam logic [2:0] OP_ROT   = 3'd5;

   typedef struct packed {
      logic [ALSU_W-1:0] a;
      logic [ALSU_W-1:0] b;
      logic [2:0]        opcode;
      logic              cin;
      logic              serial_in;
      logic              direction;
      logic              red_op_a;
      logic              red_op_b;
      logic              bypass_a;
      logic              bypass_b;
   } alsu_pins_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_EXEC,
      S_SAMPLE,
      S_RESTORE
   } drv_state_e;

   // out <= A with A = last result keeps out unchanged and clears leds.
   function automatic alsu_pins_t park_vec(input logic [ALSU_W-1:0] res);
      alsu_pins_t p;
      p          = '0;
      p.bypass_a = 1'b1;
      p.a        = res;
      return p;
   endfunction

endpackage

// File: rtl/alsu_cmd_driver.sv
// Valid/ready front end for the ALSU: issues one command, waits out the ALSU's
// two-register latency, captures out/leds and returns them with the command tag.
module alsu_cmd_driver
   import alsu_drv_pkg::*;
#(
   parameter int DATA_W = ALSU_W,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [TAG_W-1:0]  cmd_tag,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [2:0]        cmd_opcode,
   input  logic              cmd_cin,
   input  logic              cmd_serial_in,
   input  logic              cmd_direction,
   input  logic              cmd_red_op_a,
   input  logic              cmd_red_op_b,
   input  logic              cmd_bypass_a,
   input  logic              cmd_bypass_b,
   output logic [DATA_W-1:0] alsu_a,
   output logic [DATA_W-1:0] alsu_b,
   output logic [2:0]        alsu_opcode,
   output logic              alsu_cin,
   output logic              alsu_serial_in,
   output logic              alsu_direction,
   output logic              alsu_red_op_a,
   output logic              alsu_red_op_b,
   output logic              alsu_bypass_a,
   output logic              alsu_bypass_b,
   input  logic [DATA_W-1:0] alsu_out,
   input  logic [15:0]       alsu_leds,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic [DATA_W-1:0] rsp_out,
   output logic [15:0]       rsp_leds,
   output logic              rsp_invalid
);

   drv_state_e        state_q, state_d;
   alsu_pins_t        pins_q, pins_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
   logic [15:0]       rsp_leds_q, rsp_leds_d;
   logic              rsp_inv_q, rsp_inv_d;

   // Built only from registers (plus reset), so there is no path from cmd_valid.
   assign cmd_ready = !rst && (state_q == S_IDLE) && !rsp_valid_q;

   always_comb begin
      state_d     = state_q;
      pins_d      = pins_q;
      res_d       = res_q;
      tag_d       = tag_q;
      rsp_valid_d = rsp_valid_q;
      rsp_tag_d   = rsp_tag_q;
      rsp_out_d   = rsp_out_q;
      rsp_leds_d  = rsp_leds_q;
      rsp_inv_d   = rsp_inv_q;

      if (rsp_valid_q && rsp_ready)
         rsp_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               pins_d.a         = cmd_a;
               pins_d.b         = cmd_b;
               pins_d.opcode    = cmd_opcode;
               pins_d.cin       = cmd_cin;
               pins_d.serial_in = cmd_serial_in;
               pins_d.direction = cmd_direction;
               pins_d.red_op_a  = cmd_red_op_a;
               pins_d.red_op_b  = cmd_red_op_b;
               pins_d.bypass_a  = cmd_bypass_a;
               pins_d.bypass_b  = cmd_bypass_b;
               tag_d            = cmd_tag;
               state_d          = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // ALSU has taken the command; park again so out is not disturbed.
            pins_d  = park_vec(res_q);
            state_d = S_EXEC;
         end
         S_EXEC: state_d = S_SAMPLE;
         S_SAMPLE: begin
            res_d       = alsu_out;
            rsp_out_d   = alsu_out;
            rsp_leds_d  = alsu_leds;
            rsp_inv_d   = (alsu_leds == 16'hFFFF);
            rsp_tag_d   = tag_q;
            rsp_valid_d = 1'b1;
            pins_d      = park_vec(alsu_out);
            state_d     = S_RESTORE;
         end
         S_RESTORE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         pins_q      <= park_vec('0);
         res_q       <= '0;
         tag_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tag_q   <= '0;
         rsp_out_q   <= '0;
         rsp_leds_q  <= '0;
         rsp_inv_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pins_q      <= pins_d;
         res_q       <= res_d;
         tag_q       <= tag_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tag_q   <= rsp_tag_d;
         rsp_out_q   <= rsp_out_d;
         rsp_leds_q  <= rsp_leds_d;
         rsp_inv_q   <= rsp_inv_d;
      end
   end

   assign alsu_a         = pins_q.a;
   assign alsu_b         = pins_q.b;
   assign alsu_opcode    = pins_q.opcode;
   assign alsu_cin       = pins_q.cin;
   assign alsu_serial_in = pins_q.serial_in;
   assign alsu_direction = pins_q.direction;
   assign alsu_red_op_a  = pins_q.red_op_a;
   assign alsu_red_op_b  = pins_q.red_op_b;
   assign alsu_bypass_a  = pins_q.bypass_a;
   assign alsu_bypass_b  = pins_q.bypass_b;

   assign rsp_valid   = rsp_valid_q;
   assign rsp_tag     = rsp_tag_q;
   assign rsp_out     = rsp_out_q;
   assign rsp_leds    = rsp_leds_q;
   assign rsp_invalid = rsp_inv_q;

endmodule

// File: tb/tb_alsu_cmd_driver.sv
// Bench for alsu_cmd_driver: an ALSU behavioural model sits on the pins, and a
// transaction-level model predicts ready/valid, payload and pin values per cycle.
module tb_alsu_cmd_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_tag = '0;
   logic [5:0]  cmd_a = '0, cmd_b = '0;
   logic [2:0]  cmd_opcode = '0;
   logic        cmd_cin = 0, cmd_serial_in = 0, cmd_direction = 0;
   logic        cmd_red_op_a = 0, cmd_red_op_b = 0, cmd_bypass_a = 0, cmd_bypass_b = 0;
   logic [5:0]  alsu_a, alsu_b;
   logic [2:0]  alsu_opcode;
   logic        alsu_cin, alsu_serial_in, alsu_direction;
   logic        alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b;
   logic [5:0]  alsu_out;
   logic [15:0] alsu_leds;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [3:0]  rsp_tag;
   logic [5:0]  rsp_out;
   logic [15:0] rsp_leds;
   logic        rsp_invalid;

   always #5 clk = ~clk;

   alsu_cmd_driver #(.DATA_W(6), .TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tag(cmd_tag),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode),
      .cmd_cin(cmd_cin), .cmd_serial_in(cmd_serial_in), .cmd_direction(cmd_direction),
      .cmd_red_op_a(cmd_red_op_a), .cmd_red_op_b(cmd_red_op_b),
      .cmd_bypass_a(cmd_bypass_a), .cmd_bypass_b(cmd_bypass_b),
      .alsu_a(alsu_a), .alsu_b(alsu_b), .alsu_opcode(alsu_opcode),
      .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
      .alsu_red_op_a(alsu_red_op_a), .alsu_red_op_b(alsu_red_op_b),
      .alsu_bypass_a(alsu_bypass_a), .alsu_bypass_b(alsu_bypass_b),
      .alsu_out(alsu_out), .alsu_leds(alsu_leds),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
      .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid)
   );

   // ALSU function: returns {leds, out}. ctl = {cin, serial_in, direction, red_a, red_b, byp_a, byp_b}.
   function automatic logic [21:0] alsu_f(input logic [5:0] a, input logic [5:0] b,
                                          input logic [2:0] op, input logic [6:0] c,
                                          input logic [5:0] prev);
      logic [5:0] o;
      if (op > 3'd5 || ((c[3] || c[2]) && op > 3'd1)) return {16'hFFFF, 6'h00};
      if (c[1]) o = a;
      else if (c[0]) o = b;
      else case (op)
         3'd0: o = c[3] ? {5'b0, |a} : c[2] ? {5'b0, |b} : (a | b);
         3'd1: o = c[3] ? {5'b0, ^a} : c[2] ? {5'b0, ^b} : (a ^ b);
         3'd2: o = a + b + {5'b0, c[6]};
         3'd3: o = a * b;
         3'd4: o = c[4] ? {prev[4:0], c[5]} : {c[5], prev[5:1]};
         default: o = c[4] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      endcase
      return {16'h0000, o};
   endfunction

   // ALSU instance model: inputs registered, then out/leds registered.
   logic [5:0] ra_q, rb_q;
   logic [2:0] rop_q;
   logic [6:0] rctl_q;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ra_q <= '0; rb_q <= '0; rop_q <= '0; rctl_q <= '0;
         alsu_out <= '0; alsu_leds <= '0;
      end else begin
         ra_q   <= alsu_a;
         rb_q   <= alsu_b;
         rop_q  <= alsu_opcode;
         rctl_q <= {alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_a,
                    alsu_red_op_b, alsu_bypass_a, alsu_bypass_b};
         {alsu_leds, alsu_out} <= alsu_f(ra_q, rb_q, rop_q, rctl_q, alsu_out);
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [21:0] park(input logic [5:0] r);
      return {r, 6'h00, 3'h0, 7'b0000010};
   endfunction

   typedef struct {
      logic [3:0]  tag;
      logic [5:0]  a, b;
      logic [2:0]  op;
      logic [6:0]  ctl;
      logic [5:0]  lo;
      logic [15:0] ll;
   } vec_t;

   typedef struct {
      logic [3:0]  tag;
      logic [5:0]  o;
      logic [15:0] l;
      logic [5:0]  lo;
      logic [15:0] ll;
   } exp_t;

   exp_t        q[$];
   logic [5:0]  lit_out = '0;
   logic [15:0] lit_leds = '0;
   logic [5:0]  cur_res = '0, old_res = '0;
   logic [21:0] cur_pins = '0;
   int          age = 0;
   bit          busy = 0, exp_valid = 0;

   // Transaction-level model and per-cycle compare.
   always @(negedge clk) begin
      logic        exp_ready;
      logic [21:0] r, pins_act, pins_exp;
      pins_act = {alsu_a, alsu_b, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
                  alsu_red_op_a, alsu_red_op_b, alsu_bypass_a, alsu_bypass_b};
      if (rst) begin
         busy = 0; exp_valid = 0; cur_res = '0; old_res = '0; age = 0;
         q.delete();
         chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
         chk("rst_rsp_payload", {5'b0, rsp_tag, rsp_out, rsp_leds, rsp_invalid}, 32'd0);
         chk("rst_pins", {10'b0, pins_act}, {10'b0, park(6'h00)});
      end else begin
         if (busy) begin
            age++;
            if (age == 3) exp_valid = 1;
            if (age == 4) busy = 0;
         end
         exp_ready = !busy && !exp_valid;
         chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, exp_ready});
         chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
         if (exp_valid && q.size() > 0) begin
            chk("rsp_tag", {28'b0, rsp_tag}, {28'b0, q[0].tag});
            chk("rsp_out", {26'b0, rsp_out}, {26'b0, q[0].o});
            chk("rsp_out_lit", {26'b0, rsp_out}, {26'b0, q[0].lo});
            chk("rsp_leds", {16'b0, rsp_leds}, {16'b0, q[0].l});
            chk("rsp_leds_lit", {16'b0, rsp_leds}, {16'b0, q[0].ll});
            chk("rsp_invalid", {31'b0, rsp_invalid}, {31'b0, (q[0].l == 16'hFFFF)});
         end
         if (busy && age == 0) pins_exp = cur_pins;
         else if (busy && age < 3) pins_exp = park(old_res);
         else pins_exp = park(cur_res);
         chk("alsu_pins", {10'b0, pins_act}, {10'b0, pins_exp});
         if (exp_valid && rsp_ready) begin
            void'(q.pop_front());
            exp_valid = 0;
         end
         if (cmd_valid && exp_ready) begin
            r = alsu_f(cmd_a, cmd_b, cmd_opcode,
                       {cmd_cin, cmd_serial_in, cmd_direction, cmd_red_op_a,
                        cmd_red_op_b, cmd_bypass_a, cmd_bypass_b}, cur_res);
            q.push_back('{cmd_tag, r[5:0], r[21:6], lit_out, lit_leds});
            cur_pins = {cmd_a, cmd_b, cmd_opcode, cmd_cin, cmd_serial_in, cmd_direction,
                        cmd_red_op_a, cmd_red_op_b, cmd_bypass_a, cmd_bypass_b};
            old_res = cur_res;
            cur_res = r[5:0];
            busy = 1;
            age = -1;
         end
      end
   end

   task automatic start_cmd(input vec_t v);
      cmd_tag    = v.tag;
      cmd_a      = v.a;
      cmd_b      = v.b;
      cmd_opcode = v.op;
      {cmd_cin, cmd_serial_in, cmd_direction, cmd_red_op_a,
       cmd_red_op_b, cmd_bypass_a, cmd_bypass_b} = v.ctl;
      lit_out    = v.lo;
      lit_leds   = v.ll;
      cmd_valid  = 1'b1;
   endtask

   task automatic wait_accept(input string nm);
      bit got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            got = 1;
         end
      end
      chk(nm, {31'b0, got}, 32'd1);
   endtask

   vec_t vt[12];

   initial begin
      //        tag    a      b      op    ctl         lit_out lit_leds
      vt[0]  = '{4'h1, 6'h05, 6'h0A, 3'd0, 7'b0000000, 6'h0F, 16'h0000};
      vt[1]  = '{4'h2, 6'h15, 6'h00, 3'd6, 7'b0000000, 6'h00, 16'hFFFF};
      vt[2]  = '{4'h3, 6'h01, 6'h01, 3'd2, 7'b1000000, 6'h03, 16'h0000};
      vt[3]  = '{4'h4, 6'h01, 6'h00, 3'd0, 7'b0000010, 6'h01, 16'h0000};
      vt[4]  = '{4'h5, 6'h00, 6'h00, 3'd4, 7'b0110000, 6'h03, 16'h0000};
      vt[5]  = '{4'h6, 6'h00, 6'h00, 3'd5, 7'b0000000, 6'h21, 16'h0000};
      vt[6]  = '{4'h7, 6'h3E, 6'h03, 3'd3, 7'b0000000, 6'h3A, 16'h0000};
      vt[7]  = '{4'h8, 6'h07, 6'h00, 3'd1, 7'b0001000, 6'h01, 16'h0000};
      vt[8]  = '{4'h9, 6'h30, 6'h03, 3'd0, 7'b0000000, 6'h33, 16'h0000};
      vt[9]  = '{4'hA, 6'h3F, 6'h01, 3'd2, 7'b0000000, 6'h00, 16'h0000};
      vt[10] = '{4'hB, 6'h01, 6'h02, 3'd2, 7'b0000000, 6'h03, 16'h0000};
      vt[11] = '{4'hC, 6'h00, 6'h00, 3'd4, 7'b0110000, 6'h01, 16'h0000};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         start_cmd(vt[i]);
         wait_accept("accept_basic");
      end

      // Back-pressure: response held while a new command waits.
      start_cmd(vt[8]);
      wait_accept("accept_bp_first");
      rsp_ready = 1'b0;
      start_cmd(vt[9]);
      repeat (13) @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_accept("accept_after_release");

      // Reset while the command is in EXEC: dropped, history cleared.
      repeat (6) @(posedge clk);
      #1;
      start_cmd(vt[10]);
      wait_accept("accept_abort");
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      start_cmd(vt[11]);
      wait_accept("accept_post_reset");

      repeat (8) @(posedge clk);
      #1;
      chk("all_responses_seen", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
